// File: rtl/heap_root_ctrl.sv
// Level-0 controller of the dual-heapsort chain: holds the root record, performs
// replace-root on each accepted key and launches the sift into level 1.
module heap_root_ctrl #(
  parameter int DATA_W        = 32,
  parameter int LEVELS        = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [DATA_W-1:0] q_U,
  output logic [DATA_W-1:0] aux_q_U,
  input  logic [DATA_W-1:0] data_U,
  input  logic              addr_U,
  input  logic              wren_U,
  output logic              initialize,
  output logic              update_out,
  output logic              address_updated_out,
  output logic [LEVELS-1:0] occupancy,
  output logic              wr_conflict
);

  localparam logic [DATA_W-1:0] SENT = '1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOCK} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] root_q, root_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              mvalid_q, mvalid_d;
  logic              upd_q, upd_d;
  logic              init_q, init_d;
  logic              conf_q, conf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LEVELS-1:0] occ_q, occ_d;
  logic              accept, node_wr;

  assign s_ready = (state_q == S_IDLE) && (!mvalid_q || m_ready);
  assign accept  = s_valid && s_ready;
  assign node_wr = wren_U && (addr_U == 1'b0);

  always_comb begin
    state_d  = state_q;
    root_d   = root_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    upd_d    = 1'b0;
    init_d   = 1'b0;
    conf_d   = conf_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;

    // Node writes land in any state; an accept in the same cycle overrides them.
    if (node_wr) root_d = data_U;
    if (mvalid_q && m_ready) mvalid_d = 1'b0;

    unique case (state_q)
      S_INIT: begin
        // First clock raises initialize, second clock drops it and opens input.
        init_d  = !init_q;
        state_d = init_q ? S_IDLE : S_INIT;
      end
      S_IDLE: begin
        if (accept) begin
          mdata_d  = root_q;
          mvalid_d = (root_q != SENT);
          root_d   = s_data;
          upd_d    = 1'b1;
          cnt_d    = CNT_RELOAD;
          occ_d    = occ_q + LEVELS'(s_data != SENT) - LEVELS'(root_q != SENT);
          if (node_wr) conf_d = 1'b1;
          state_d  = S_LOCK;
        end
      end
      S_LOCK: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      root_q   <= SENT;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      upd_q    <= 1'b0;
      init_q   <= 1'b0;
      conf_q   <= 1'b0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      root_q   <= root_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      upd_q    <= upd_d;
      init_q   <= init_d;
      conf_q   <= conf_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
    end
  end

  assign m_valid             = mvalid_q;
  assign m_data              = mdata_q;
  assign q_U                 = root_q;
  assign aux_q_U             = root_q;
  assign initialize          = init_q;
  assign update_out          = upd_q;
  assign address_updated_out = 1'b0;
  assign occupancy           = occ_q;
  assign wr_conflict         = conf_q;

endmodule

// File: tb/tb_heap_root_ctrl.sv
// Randomized bench for heap_root_ctrl against a cycle-level model of the
// replace-root rules (lockout tracked as cycles since the last accept).
module tb_heap_root_ctrl;
  localparam int SETTLE = 4;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b1;
  logic        s_valid = 1'b0, m_ready = 1'b0, addr_U = 1'b0, wren_U = 1'b0;
  logic [31:0] s_data = '0, data_U = '0;
  logic        s_ready, m_valid, initialize, update_out, address_updated_out, wr_conflict;
  logic [31:0] m_data, q_U, aux_q_U;
  logic [3:0]  occupancy;

  heap_root_ctrl #(.DATA_W(32), .LEVELS(4), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .q_U(q_U), .aux_q_U(aux_q_U),
    .data_U(data_U), .addr_U(addr_U), .wren_U(wren_U), .initialize(initialize),
    .update_out(update_out), .address_updated_out(address_updated_out),
    .occupancy(occupancy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference state
  logic [31:0] root_m, md_m;
  logic        mv_m, upd_m, conf_m, acc_m;
  int          occ_m, ph, gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    root_m = SENT; md_m = '0; mv_m = 1'b0; upd_m = 1'b0; conf_m = 1'b0;
    acc_m = 1'b0; occ_m = 0; ph = 0; gap = 1000;
  endtask

  task automatic chk_reset_vals();
    chk("rst_q_U", q_U, SENT);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_update", update_out, 0);
    chk("rst_init", initialize, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_conflict", wr_conflict, 0);
    chk("rst_s_ready", s_ready, 0);
  endtask

  // Called at a negedge; checks outputs, drives inputs, advances model; ends at next negedge.
  task automatic cycle(input logic sv, input logic [31:0] sd, input logic mr,
                       input logic wr, input logic ad, input logic [31:0] wd);
    logic srm;
    chk("q_U", q_U, root_m);
    chk("aux_q_U", aux_q_U, root_m);
    chk("m_valid", m_valid, mv_m);
    chk("m_data", m_data, md_m);
    chk("update_out", update_out, upd_m);
    chk("initialize", initialize, ph == 1);
    chk("occupancy", occupancy, occ_m);
    chk("wr_conflict", wr_conflict, conf_m);
    chk("addr_updated", address_updated_out, 0);
    s_valid = sv; s_data = sd; m_ready = mr; wren_U = wr; addr_U = ad; data_U = wd;
    #1;
    srm = (ph == 2) && (gap > SETTLE) && (!mv_m || mr);
    chk("s_ready", s_ready, srm);
    acc_m = sv && srm;
    if (acc_m) begin
      occ_m = occ_m + int'(sd != SENT) - int'(root_m != SENT);
      md_m = root_m;
      mv_m = (root_m != SENT);
      if (wr && !ad) conf_m = 1'b1;
      root_m = sd;
      gap = 1;
      upd_m = 1'b1;
    end else begin
      if (mv_m && mr) mv_m = 1'b0;
      if (wr && !ad) root_m = wd;
      gap++;
      upd_m = 1'b0;
    end
    if (ph < 2) ph++;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] key, input logic wr, input logic [31:0] wd);
    for (int n = 0; n < 40; n++) begin
      cycle(1'b1, key, 1'b1, wr, 1'b0, wd);
      if (acc_m) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic sv, mr, wr, ad;
    logic [31:0] sd, wd;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    idle(3);

    // 5 then 3, spaced by lockout
    send(32'd5, 1'b0, '0);
    idle(4);
    send(32'd3, 1'b0, '0);
    // back-to-back 9,8 with s_valid held high
    send(32'd9, 1'b0, '0);
    send(32'd8, 1'b0, '0);
    idle(5);
    send(32'd12, 1'b0, '0);
    // backpressure: hold m_ready low, then release with s_valid pending
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'd6, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'd6, 1'b1, 1'b0, 1'b0, '0);
    idle(5);
    // node write during LOCK, then pop it
    send(32'd10, 1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd2);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'd77);
    idle(3);
    send(32'd20, 1'b0, '0);
    idle(4);
    // node write coinciding with accept
    send(32'd30, 1'b1, 32'd1);
    idle(4);
    // fill and flush
    send(32'd7, 1'b0, '0);
    send(32'd1, 1'b0, '0);
    send(32'd4, 1'b0, '0);
    for (int k = 0; k < 3; k++) send(SENT, 1'b0, '0);
    idle(5);

    // randomized traffic with level-1 style swaps of a smaller key into the root
    for (int i = 0; i < 1500; i++) begin
      sv = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? SENT : 32'($urandom_range(0, 1000));
      mr = ($urandom_range(0, 3) != 0);
      wr = 1'b0; ad = 1'b0; wd = '0;
      if (root_m != SENT && root_m != 0 && $urandom_range(0, 5) == 0) begin
        wr = 1'b1; wd = $urandom_range(0, root_m - 1);
      end else if ($urandom_range(0, 9) == 0) begin
        wr = 1'b1; ad = 1'b1; wd = $urandom;
      end
      cycle(sv, sd, mr, wr, ad, wd);
    end
    idle(6);

    // reset in the middle of LOCK with the conflict flag set
    send(32'd40, 1'b1, 32'd3);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    send(32'd5, 1'b0, '0);
    send(32'd8, 1'b0, '0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
